// File: rtl/divmod_wb_buffer_if.sv
// Bundle of the divider-result and writeback-port signals around divmod_wb_buffer.
// The slave modport is the buffer itself; the master modport is the surrounding pipeline.
interface divmod_wb_buffer_if;
  logic        flush_back;
  logic        issue_fire;
  logic        is_divmod;
  logic [31:0] Result_divmod;
  logic [5:0]  Pd_divmod;
  logic        ready_divmod;
  logic        RegWr_divmod;
  logic [5:0]  tag_rob_divmod;
  logic        wb_grant;

  logic        wb_valid;
  logic [31:0] wb_result;
  logic [5:0]  wb_Pd;
  logic        wb_ready;
  logic        wb_RegWr;
  logic [5:0]  wb_tag_rob;
  logic        stall_div;
  logic        overflow_err;

  modport master (
    output flush_back, issue_fire, is_divmod, Result_divmod, Pd_divmod,
           ready_divmod, RegWr_divmod, tag_rob_divmod, wb_grant,
    input  wb_valid, wb_result, wb_Pd, wb_ready, wb_RegWr, wb_tag_rob,
           stall_div, overflow_err
  );

  modport slave (
    input  flush_back, issue_fire, is_divmod, Result_divmod, Pd_divmod,
           ready_divmod, RegWr_divmod, tag_rob_divmod, wb_grant,
    output wb_valid, wb_result, wb_Pd, wb_ready, wb_RegWr, wb_tag_rob,
           stall_div, overflow_err
  );
endinterface

// File: rtl/divmod_wb_buffer.sv
// Writeback buffer between the div/mod pipeline and a shared writeback port.
// Define DIVMOD_WB_BYPASS_EN to let a result arriving at an empty buffer go straight to wb_*.
module divmod_wb_buffer #(
  parameter int DEPTH    = 4,
  parameter int DIV_TIME = 16
) (
  input logic               clk,
  input logic               rst,
  divmod_wb_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 ||
      DIV_TIME < 1 || DIV_TIME > 31) begin : g_bad_param
    $error("divmod_wb_buffer: DEPTH must be a power of two in 2..16 and DIV_TIME in 1..31");
  end

  typedef struct packed {
    logic [31:0] result;
    logic [5:0]  pd;
    logic        ready;
    logic        regwr;
    logic [5:0]  tag;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [4:0]    inflight;
  logic          overflow;

  entry_t        in_entry;
  entry_t        head_entry;
  entry_t        wb_entry;
  logic          empty;
  logic          full;
  logic          bypass_take;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          drop;
  logic          stall;
  logic [5:0]    occupancy;

  assign in_entry   = '{result: bus.Result_divmod, pd: bus.Pd_divmod,
                        ready: bus.ready_divmod, regwr: bus.RegWr_divmod,
                        tag: bus.tag_rob_divmod};
  assign head_entry = mem[head];
  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));

`ifdef DIVMOD_WB_BYPASS_EN
  // Bypass is gated by rst so wb_valid stays low while reset is held.
  logic bypass;
  assign bypass      = rst && !bus.flush_back && empty && bus.is_divmod;
  assign bypass_take = bypass && bus.wb_grant;
  assign wb_entry    = bypass ? in_entry : head_entry;
  assign bus.wb_valid = !empty || bypass;
`else
  assign bypass_take  = 1'b0;
  assign wb_entry     = head_entry;
  assign bus.wb_valid = !empty;
`endif

  assign bus.wb_result  = wb_entry.result;
  assign bus.wb_Pd      = wb_entry.pd;
  assign bus.wb_ready   = wb_entry.ready;
  assign bus.wb_RegWr   = wb_entry.regwr;
  assign bus.wb_tag_rob = wb_entry.tag;

  // A full buffer still accepts a result when the head leaves in the same cycle.
  assign pop      = !empty && bus.wb_grant && !bus.flush_back;
  assign push_req = bus.is_divmod && !bus.flush_back && !bypass_take;
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign occupancy        = 6'(count) + 6'(inflight);
  assign stall            = (occupancy >= 6'(DEPTH));
  assign bus.stall_div    = stall;
  assign bus.overflow_err = overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
      overflow <= 1'b0;
    end else if (bus.flush_back) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      // Results can outnumber issues right after reset, so inflight floors at zero.
      if (bus.issue_fire && !bus.is_divmod && inflight != 5'd31)
        inflight <= inflight + 5'd1;
      else if (!bus.issue_fire && bus.is_divmod && inflight != 5'd0)
        inflight <= inflight - 5'd1;
      if (drop || (bus.issue_fire && stall))
        overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_entry;
  end

endmodule
